// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC decoder control path: sequencer state
// encoding and default phase lengths that track the vnu/cnu pipeline depths.
package ldpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_VNU  = 3'd2,
    ST_CNU  = 3'd3,
    ST_CHK  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // vnu: sum register + output register; cnu: same two-stage depth
  localparam int VNU_LAT_DEF = 2;
  localparam int CNU_LAT_DEF = 2;

endpackage

// File: rtl/ldpc_phase_cnt.sv
// Phase-length counter: counts while enabled, flags when the count equals the
// terminal value, and returns to zero on clear (clear has priority).
module ldpc_phase_cnt #(
  parameter int PH_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [PH_W-1:0] term,
  output logic            tc
);

  logic [PH_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PH_W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Flooding-schedule LDPC iteration sequencer: load, VNU, CNU and syndrome
// phases with early stop on zero syndrome or at the iteration limit.
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 4,
  parameter int VNU_LAT  = VNU_LAT_DEF,
  parameter int CNU_LAT  = CNU_LAT_DEF,
  parameter int PH_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              syn_vld,
  input  logic              syn_ok,
  input  logic              out_rdy,
  output logic              busy,
  output logic              load_en,
  output logic              vnu_en,
  output logic              cnu_en,
  output logic              chk_en,
  output logic              out_vld,
  output logic              converged,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t          state, state_next;
  logic            ph_clr, ph_en, ph_tc;
  logic [PH_W-1:0] ph_term;
  logic            iter_clr, iter_inc, conv_set;

  // One counter serves both compute phases; only the terminal value changes.
  assign ph_term = (state == ST_CNU) ? PH_W'(CNU_LAT - 1) : PH_W'(VNU_LAT - 1);

  ldpc_phase_cnt #(.PH_W(PH_W)) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (ph_clr),
    .en   (ph_en),
    .term (ph_term),
    .tc   (ph_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ph_clr     = 1'b1;
    ph_en      = 1'b0;
    iter_clr   = 1'b0;
    iter_inc   = 1'b0;
    conv_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          iter_clr   = 1'b1;
        end
      end
      ST_LOAD: state_next = ST_VNU;
      ST_VNU: begin
        ph_en  = 1'b1;
        ph_clr = ph_tc;
        if (ph_tc) state_next = ST_CNU;
      end
      ST_CNU: begin
        ph_en  = 1'b1;
        ph_clr = ph_tc;
        if (ph_tc) begin
          state_next = ST_CHK;
          iter_inc   = 1'b1;
        end
      end
      ST_CHK: begin
        // convergence is checked first so it wins on the last iteration
        if (syn_vld) begin
          if (syn_ok) begin
            state_next = ST_OUT;
            conv_set   = 1'b1;
          end else if (iter_cnt == ITER_W'(MAX_ITER)) begin
            state_next = ST_OUT;
          end else begin
            state_next = ST_VNU;
          end
        end
      end
      ST_OUT: begin
        if (out_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt  <= '0;
      converged <= 1'b0;
    end else if (iter_clr) begin
      iter_cnt  <= '0;
      converged <= 1'b0;
    end else begin
      if (iter_inc && (iter_cnt != ITER_W'(MAX_ITER))) begin
        iter_cnt <= iter_cnt + ITER_W'(1);
      end
      if (conv_set) begin
        converged <= 1'b1;
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign load_en = (state == ST_LOAD);
  assign vnu_en  = (state == ST_VNU);
  assign cnu_en  = (state == ST_CNU);
  assign chk_en  = (state == ST_CHK);
  assign out_vld = (state == ST_OUT);

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed cycle-by-cycle bench for ldpc_iter_ctrl with MAX_ITER=3,
// VNU_LAT=2, CNU_LAT=2: convergence, limit, stalls, backpressure, reset.
module tb_ldpc_iter_ctrl;
  import ldpc_pkg::*;

  localparam int MAX_ITER = 3;
  localparam int ITER_W   = 4;
  localparam int VNU_LAT  = 2;
  localparam int CNU_LAT  = 2;
  localparam int PH_W     = 4;

  logic              clk = 1'b0;
  logic              rst, start, syn_vld, syn_ok, out_rdy;
  logic              busy, load_en, vnu_en, cnu_en, chk_en, out_vld, converged;
  logic [ITER_W-1:0] iter_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  ldpc_iter_ctrl #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W),
    .VNU_LAT  (VNU_LAT),
    .CNU_LAT  (CNU_LAT),
    .PH_W     (PH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .syn_vld   (syn_vld),
    .syn_ok    (syn_ok),
    .out_rdy   (out_rdy),
    .busy      (busy),
    .load_en   (load_en),
    .vnu_en    (vnu_en),
    .cnu_en    (cnu_en),
    .chk_en    (chk_en),
    .out_vld   (out_vld),
    .converged (converged),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {busy, load_en, vnu_en, cnu_en, chk_en, out_vld} for each state
  function automatic logic [5:0] outs_for(input state_t s);
    case (s)
      ST_LOAD: return 6'b110000;
      ST_VNU:  return 6'b101000;
      ST_CNU:  return 6'b100100;
      ST_CHK:  return 6'b100010;
      ST_OUT:  return 6'b100001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic expect_cyc(input string tag, input state_t s, input int it, input logic cv);
    check($sformatf("%s c%0d outs", tag, cyc_n),
          {26'd0, busy, load_en, vnu_en, cnu_en, chk_en, out_vld}, {26'd0, outs_for(s)});
    check($sformatf("%s c%0d iter", tag, cyc_n), 32'(iter_cnt), 32'(it));
    check($sformatf("%s c%0d conv", tag, cyc_n), 32'(converged), 32'(cv));
  endtask

  // start sampled at edge 0, leaves the bench in cycle 1
  task automatic kick();
    cyc_n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // VNU then CNU phases; returns positioned in the following CHK cycle
  task automatic phases(input string tag, input int it);
    for (int i = 0; i < VNU_LAT; i++) begin
      expect_cyc(tag, ST_VNU, it, 1'b0);
      step();
    end
    for (int i = 0; i < CNU_LAT; i++) begin
      expect_cyc(tag, ST_CNU, it, 1'b0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; syn_vld = 1'b0; syn_ok = 1'b0; out_rdy = 1'b0;
    step();
    step();
    expect_cyc("rst", ST_IDLE, 0, 1'b0);
    rst = 1'b0;
    step();
    expect_cyc("rst_rel", ST_IDLE, 0, 1'b0);
    $display("txn reset: checked");

    // Early convergence in the first CHK
    syn_vld = 1'b1; syn_ok = 1'b1; out_rdy = 1'b1;
    kick();
    expect_cyc("conv", ST_LOAD, 0, 1'b0); step();
    phases("conv", 0);
    check("conv chk cycle", 32'(cyc_n), 32'd6);
    expect_cyc("conv", ST_CHK, 1, 1'b0); step();
    expect_cyc("conv", ST_OUT, 1, 1'b1); step();
    expect_cyc("conv", ST_IDLE, 1, 1'b1);
    $display("txn early_conv: out at cycle 7, iter=%0d conv=%0d", iter_cnt, converged);

    // Iteration limit, syndrome never satisfied
    syn_ok = 1'b0;
    kick();
    expect_cyc("lim", ST_LOAD, 0, 1'b0); step();
    for (int k = 0; k < MAX_ITER; k++) begin
      phases("lim", k);
      check($sformatf("lim chk%0d cycle", k), 32'(cyc_n), 32'(6 + 5 * k));
      expect_cyc("lim", ST_CHK, k + 1, 1'b0); step();
    end
    check("lim out cycle", 32'(cyc_n), 32'd17);
    expect_cyc("lim", ST_OUT, 3, 1'b0); step();
    expect_cyc("lim", ST_IDLE, 3, 1'b0);
    $display("txn iter_limit: iter=%0d conv=%0d", iter_cnt, converged);

    // Syndrome stall followed by output backpressure with ignored starts
    syn_vld = 1'b0; syn_ok = 1'b0; out_rdy = 1'b0;
    kick();
    expect_cyc("stall", ST_LOAD, 0, 1'b0); step();
    phases("stall", 0);
    for (int i = 0; i < 4; i++) begin
      expect_cyc("stall", ST_CHK, 1, 1'b0); step();
    end
    syn_vld = 1'b1; syn_ok = 1'b1;
    expect_cyc("stall", ST_CHK, 1, 1'b0); step();
    syn_vld = 1'b0; syn_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      expect_cyc("bp", ST_OUT, 1, 1'b1); step();
    end
    start = 1'b0; out_rdy = 1'b1;
    expect_cyc("bp", ST_OUT, 1, 1'b1); step();
    check("bp idle cycle", 32'(cyc_n), 32'd15);
    expect_cyc("bp", ST_IDLE, 1, 1'b1); step();
    expect_cyc("bp", ST_IDLE, 1, 1'b1);
    $display("txn stall_backpressure: released at cycle 14");

    // start coinciding with the completing handshake is dropped
    syn_vld = 1'b1; syn_ok = 1'b1; out_rdy = 1'b1;
    kick();
    expect_cyc("sio", ST_LOAD, 0, 1'b0); step();
    phases("sio", 0);
    expect_cyc("sio", ST_CHK, 1, 1'b0); step();
    start = 1'b1;
    expect_cyc("sio", ST_OUT, 1, 1'b1); step();
    expect_cyc("sio", ST_IDLE, 1, 1'b1); step();
    start = 1'b0;
    expect_cyc("sio", ST_LOAD, 0, 1'b0); step();
    phases("sio2", 0);
    expect_cyc("sio2", ST_CHK, 1, 1'b0); step();
    expect_cyc("sio2", ST_OUT, 1, 1'b1); step();
    expect_cyc("sio2", ST_IDLE, 1, 1'b1);
    $display("txn start_in_out: restart after idle");

    // Reset in the middle of the second CNU phase
    syn_ok = 1'b0;
    kick();
    expect_cyc("mrst", ST_LOAD, 0, 1'b0); step();
    phases("mrst", 0);
    expect_cyc("mrst", ST_CHK, 1, 1'b0); step();
    expect_cyc("mrst", ST_VNU, 1, 1'b0); step();
    expect_cyc("mrst", ST_VNU, 1, 1'b0); step();
    expect_cyc("mrst", ST_CNU, 1, 1'b0);
    rst = 1'b1;
    step();
    expect_cyc("mrst", ST_IDLE, 0, 1'b0);
    rst = 1'b0;
    step();
    expect_cyc("mrst_rel", ST_IDLE, 0, 1'b0); step();
    expect_cyc("mrst_rel", ST_IDLE, 0, 1'b0);
    $display("txn mid_reset: idle after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
